// File: rtl/lectura_rtc_if.sv
// RTC read bus for lectura_rtc: start/busy/done handshake, address/data bus and captured bytes.
interface lectura_rtc_if;
   logic       leer;
   logic [7:0] data_in;
   logic [7:0] address;
   logic       busy;
   logic       done;
   logic [7:0] segundos;
   logic [7:0] minutos;
   logic [7:0] horas;
   logic [7:0] dia;
   logic [7:0] mes;
   logic [7:0] anio;
   logic [7:0] dia_sem;
   logic [7:0] num_sem;
   logic [7:0] t_seg;
   logic [7:0] t_min;
   logic [7:0] t_hora;

   modport master (
      input  leer, data_in,
      output address, busy, done,
      output segundos, minutos, horas, dia, mes, anio, dia_sem, num_sem,
      output t_seg, t_min, t_hora
   );

   modport slave (
      output leer, data_in,
      input  address, busy, done,
      input  segundos, minutos, horas, dia, mes, anio, dia_sem, num_sem,
      input  t_seg, t_min, t_hora
   );
endinterface

// File: rtl/lectura_rtc.sv
// Sequential RTC register reader: walks addresses 21h..28h (and 41h..43h when
// LECTURA_TIMER_EN is defined), holding each HOLD cycles before sampling data_in.
module lectura_rtc #(
   parameter logic [11:0] HOLD = 12'h04A
) (
   input  logic           clk,
   input  logic           reset,
   lectura_rtc_if.master  bus
);

   typedef enum logic [1:0] {S_IDLE, S_HOLD, S_DONE} state_t;

`ifdef LECTURA_TIMER_EN
   localparam logic [3:0] LAST = 4'd10;
`else
   localparam logic [3:0] LAST = 4'd7;
`endif

   state_t      state;
   logic [11:0] cnt;
   logic [3:0]  idx;
   logic [7:0]  address_q;
   logic        busy_q;
   logic        done_q;
   logic [7:0]  seg_q, min_q, hora_q, dia_q, mes_q, anio_q, dsem_q, nsem_q;
   logic [7:0]  tseg_q, tmin_q, thora_q;

   // Entries past the last one of this build read as "not reading".
   function automatic logic [7:0] addr_of(input logic [3:0] i);
      logic [7:0] a;
      a = 8'h00;
      if (i <= LAST) begin
         if (i < 4'd8) a = 8'h21 + {4'h0, i};
         else          a = 8'h41 + {4'h0, i} - 8'd8;
      end
      return a;
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         cnt       <= 12'd1;
         idx       <= 4'd0;
         address_q <= 8'h00;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         seg_q     <= 8'h00;
         min_q     <= 8'h00;
         hora_q    <= 8'h00;
         dia_q     <= 8'h00;
         mes_q     <= 8'h00;
         anio_q    <= 8'h00;
         dsem_q    <= 8'h00;
         nsem_q    <= 8'h00;
         tseg_q    <= 8'h00;
         tmin_q    <= 8'h00;
         thora_q   <= 8'h00;
      end else begin
         case (state)
            S_IDLE: begin
               done_q    <= 1'b0;
               busy_q    <= 1'b0;
               address_q <= 8'h00;
               cnt       <= 12'd1;
               idx       <= 4'd0;
               if (bus.leer) begin
                  state     <= S_HOLD;
                  address_q <= addr_of(4'd0);
                  busy_q    <= 1'b1;
               end
            end

            S_HOLD: begin
               if (idx > LAST) begin
                  state     <= S_IDLE;
                  address_q <= 8'h00;
                  busy_q    <= 1'b0;
                  cnt       <= 12'd1;
                  idx       <= 4'd0;
               end else if (cnt == HOLD) begin
                  cnt <= 12'd1;
                  case (idx)
                     4'd0: seg_q  <= bus.data_in;
                     4'd1: min_q  <= bus.data_in;
                     4'd2: hora_q <= bus.data_in;
                     4'd3: dia_q  <= bus.data_in;
                     4'd4: mes_q  <= bus.data_in;
                     4'd5: anio_q <= bus.data_in;
                     4'd6: dsem_q <= bus.data_in;
                     4'd7: nsem_q <= bus.data_in;
`ifdef LECTURA_TIMER_EN
                     4'd8:  tseg_q  <= bus.data_in;
                     4'd9:  tmin_q  <= bus.data_in;
                     4'd10: thora_q <= bus.data_in;
`endif
                     default: ;
                  endcase
                  // Address moves on the capture edge so the next entry gets a full HOLD window.
                  if (idx == LAST) begin
                     state     <= S_DONE;
                     done_q    <= 1'b1;
                     busy_q    <= 1'b0;
                     address_q <= 8'h00;
                  end else begin
                     idx       <= idx + 4'd1;
                     address_q <= addr_of(idx + 4'd1);
                  end
               end else begin
                  cnt <= cnt + 12'd1;
               end
            end

            S_DONE: begin
               state     <= S_IDLE;
               done_q    <= 1'b0;
               busy_q    <= 1'b0;
               address_q <= 8'h00;
               idx       <= 4'd0;
               cnt       <= 12'd1;
            end

            default: begin
               state     <= S_IDLE;
               done_q    <= 1'b0;
               busy_q    <= 1'b0;
               address_q <= 8'h00;
            end
         endcase
      end
   end

   assign bus.address  = address_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.segundos = seg_q;
   assign bus.minutos  = min_q;
   assign bus.horas    = hora_q;
   assign bus.dia      = dia_q;
   assign bus.mes      = mes_q;
   assign bus.anio     = anio_q;
   assign bus.dia_sem  = dsem_q;
   assign bus.num_sem  = nsem_q;
`ifdef LECTURA_TIMER_EN
   assign bus.t_seg    = tseg_q;
   assign bus.t_min    = tmin_q;
   assign bus.t_hora   = thora_q;
`else
   // Timer bytes are tied off when the timer entries are not part of the sequence.
   assign bus.t_seg    = 8'h00;
   assign bus.t_min    = 8'h00;
   assign bus.t_hora   = 8'h00;
`endif

endmodule

// File: tb/tb_lectura_rtc.sv
// Directed bench for lectura_rtc: one DUT with HOLD=74, a second with HOLD=2.
module tb_lectura_rtc;

   localparam int H  = 74;
   localparam int H2 = 2;
`ifdef LECTURA_TIMER_EN
   localparam int N = 11;
`else
   localparam int N = 8;
`endif

   logic clk;
   logic reset;
   logic [7:0] off_a;
   logic [7:0] off_b;
   int checks;
   int errors;

   lectura_rtc_if bus_a ();
   lectura_rtc_if bus_b ();

   // RTC model: returns address plus an offset chosen per scenario.
   assign bus_a.data_in = bus_a.address + off_a;
   assign bus_b.data_in = bus_b.address + off_b;

   lectura_rtc #(.HOLD(12'd74)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
   lectura_rtc #(.HOLD(12'd2))  dut_b (.clk(clk), .reset(reset), .bus(bus_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] exp_addr(input int i);
      logic [7:0] a;
      if (i < 8) a = 8'h21 + 8'(i);
      else       a = 8'h41 + 8'(i - 8);
      return a;
   endfunction

   function automatic logic [7:0] exp_cap(input int i, input logic [7:0] off);
      logic [7:0] v;
      v = (i < N) ? exp_addr(i) + off : 8'h00;
      return v;
   endfunction

   function automatic logic [7:0] cap_a(input int i);
      logic [7:0] v;
      case (i)
         0: v = bus_a.segundos;  1: v = bus_a.minutos;  2: v = bus_a.horas;
         3: v = bus_a.dia;       4: v = bus_a.mes;      5: v = bus_a.anio;
         6: v = bus_a.dia_sem;   7: v = bus_a.num_sem;  8: v = bus_a.t_seg;
         9: v = bus_a.t_min;     default: v = bus_a.t_hora;
      endcase
      return v;
   endfunction

   function automatic logic [7:0] cap_b(input int i);
      logic [7:0] v;
      case (i)
         0: v = bus_b.segundos;  1: v = bus_b.minutos;  2: v = bus_b.horas;
         3: v = bus_b.dia;       4: v = bus_b.mes;      5: v = bus_b.anio;
         6: v = bus_b.dia_sem;   7: v = bus_b.num_sem;  8: v = bus_b.t_seg;
         9: v = bus_b.t_min;     default: v = bus_b.t_hora;
      endcase
      return v;
   endfunction

   task automatic test_reset();
      logic [9:0] got;
      reset = 1'b0;
      bus_a.leer = 1'b0;
      bus_b.leer = 1'b0;
      repeat (3) tick();
      reset = 1'b1;
      for (int k = 0; k < 100; k++) begin
         tick();
         got = {bus_a.address, bus_a.busy, bus_a.done};
         checks++;
         if (got !== 10'h000) begin
            errors++;
            $display("FAIL reset_idle_a cycle %0d got %h exp 000", k, got);
         end
      end
      got = {bus_b.address, bus_b.busy, bus_b.done};
      checks++;
      if (got !== 10'h000) begin
         errors++;
         $display("FAIL reset_idle_b got %h exp 000", got);
      end
      for (int i = 0; i < 11; i++) begin
         checks++;
         if (cap_a(i) !== 8'h00 || cap_b(i) !== 8'h00) begin
            errors++;
            $display("FAIL reset_cap%0d got %h/%h exp 00", i, cap_a(i), cap_b(i));
         end
      end
   endtask

   task automatic test_sequence();
      logic [9:0] got, exp;
      logic [7:0] es;
      int dones;
      off_a = 8'h01;
      dones = 0;
      bus_a.leer = 1'b1;
      tick();
      bus_a.leer = 1'b0;
      got = {bus_a.address, bus_a.busy, bus_a.done};
      checks++;
      if (got !== {8'h21, 2'b10}) begin
         errors++;
         $display("FAIL seq_start got %h exp %h", got, {8'h21, 2'b10});
      end
      for (int k = 1; k <= N * H + 1; k++) begin
         tick();
         if (k < N * H)       exp = {exp_addr(k / H), 2'b10};
         else if (k == N * H) exp = {8'h00, 2'b01};
         else                 exp = 10'h000;
         got = {bus_a.address, bus_a.busy, bus_a.done};
         if (bus_a.done) dones++;
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL seq_addr edge %0d got %h exp %h", k, got, exp);
         end
         es = (k >= H) ? 8'h22 : 8'h00;
         checks++;
         if (bus_a.segundos !== es) begin
            errors++;
            $display("FAIL seq_seg_hold edge %0d got %h exp %h", k, bus_a.segundos, es);
         end
         // A leer pulse in the middle of HOLD must not disturb the walk.
         if (k == 100) bus_a.leer = 1'b1;
         if (k == 101) bus_a.leer = 1'b0;
      end
      checks++;
      if (dones != 1) begin
         errors++;
         $display("FAIL seq_done_count got %0d exp 1", dones);
      end
      for (int i = 0; i < 11; i++) begin
         checks++;
         if (cap_a(i) !== exp_cap(i, 8'h01)) begin
            errors++;
            $display("FAIL seq_cap%0d got %h exp %h", i, cap_a(i), exp_cap(i, 8'h01));
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [9:0] got, exp;
      logic [7:0] en;
      int dones;
      int s2;
      off_a = 8'h03;
      dones = 0;
      s2 = N * H + 2;
      bus_a.leer = 1'b1;
      tick();
      for (int k = 1; k <= 2 * N * H + 2; k++) begin
         tick();
         if (k < N * H)            exp = {exp_addr(k / H), 2'b10};
         else if (k == N * H)      exp = {8'h00, 2'b01};
         else if (k == N * H + 1)  exp = 10'h000;
         else if (k < s2 + N * H)  exp = {exp_addr((k - s2) / H), 2'b10};
         else                      exp = {8'h00, 2'b01};
         got = {bus_a.address, bus_a.busy, bus_a.done};
         if (bus_a.done) dones++;
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL b2b_addr edge %0d got %h exp %h", k, got, exp);
         end
         en = (k >= 8 * H) ? 8'h2B : 8'h29;
         checks++;
         if (bus_a.num_sem !== en) begin
            errors++;
            $display("FAIL b2b_numsem_hold edge %0d got %h exp %h", k, bus_a.num_sem, en);
         end
      end
      bus_a.leer = 1'b0;
      for (int k = 0; k < 2; k++) begin
         tick();
         got = {bus_a.address, bus_a.busy, bus_a.done};
         checks++;
         if (got !== 10'h000) begin
            errors++;
            $display("FAIL b2b_tail %0d got %h exp 000", k, got);
         end
      end
      checks++;
      if (dones != 2) begin
         errors++;
         $display("FAIL b2b_done_count got %0d exp 2", dones);
      end
      for (int i = 0; i < 11; i++) begin
         checks++;
         if (cap_a(i) !== exp_cap(i, 8'h03)) begin
            errors++;
            $display("FAIL b2b_cap%0d got %h exp %h", i, cap_a(i), exp_cap(i, 8'h03));
         end
      end
   endtask

   task automatic test_reset_abort();
      logic [9:0] got, exp;
      int dones;
      off_a = 8'h05;
      dones = 0;
      bus_a.leer = 1'b1;
      tick();
      bus_a.leer = 1'b0;
      repeat (300) tick();
      got = {bus_a.address, bus_a.busy, bus_a.done};
      checks++;
      if (got !== {8'h25, 2'b10} || bus_a.segundos !== 8'h26) begin
         errors++;
         $display("FAIL abort_pre got %h seg %h exp %h seg 26", got, bus_a.segundos, {8'h25, 2'b10});
      end
      reset = 1'b0;
      #1;
      got = {bus_a.address, bus_a.busy, bus_a.done};
      checks++;
      if (got !== 10'h000) begin
         errors++;
         $display("FAIL abort_async got %h exp 000", got);
      end
      for (int i = 0; i < 11; i++) begin
         checks++;
         if (cap_a(i) !== 8'h00) begin
            errors++;
            $display("FAIL abort_cap%0d got %h exp 00", i, cap_a(i));
         end
      end
      repeat (3) tick();
      reset = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         got = {bus_a.address, bus_a.busy, bus_a.done};
         checks++;
         if (got !== 10'h000) begin
            errors++;
            $display("FAIL abort_idle %0d got %h exp 000", k, got);
         end
      end
      bus_a.leer = 1'b1;
      tick();
      bus_a.leer = 1'b0;
      for (int k = 1; k <= N * H + 1; k++) begin
         tick();
         if (k < N * H)       exp = {exp_addr(k / H), 2'b10};
         else if (k == N * H) exp = {8'h00, 2'b01};
         else                 exp = 10'h000;
         got = {bus_a.address, bus_a.busy, bus_a.done};
         if (bus_a.done) dones++;
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL restart_addr edge %0d got %h exp %h", k, got, exp);
         end
      end
      checks++;
      if (dones != 1) begin
         errors++;
         $display("FAIL restart_done_count got %0d exp 1", dones);
      end
      for (int i = 0; i < 11; i++) begin
         checks++;
         if (cap_a(i) !== exp_cap(i, 8'h05)) begin
            errors++;
            $display("FAIL restart_cap%0d got %h exp %h", i, cap_a(i), exp_cap(i, 8'h05));
         end
      end
   endtask

   task automatic test_hold2();
      logic [9:0] got, exp;
      off_b = 8'h01;
      bus_b.leer = 1'b1;
      tick();
      bus_b.leer = 1'b0;
      for (int k = 1; k <= N * H2 + 1; k++) begin
         tick();
         if (k < N * H2)       exp = {exp_addr(k / H2), 2'b10};
         else if (k == N * H2) exp = {8'h00, 2'b01};
         else                  exp = 10'h000;
         got = {bus_b.address, bus_b.busy, bus_b.done};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL hold2_addr edge %0d got %h exp %h", k, got, exp);
         end
      end
      for (int i = 0; i < 11; i++) begin
         checks++;
         if (cap_b(i) !== exp_cap(i, 8'h01)) begin
            errors++;
            $display("FAIL hold2_cap%0d got %h exp %h", i, cap_b(i), exp_cap(i, 8'h01));
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      off_a = 8'h00;
      off_b = 8'h00;
      reset = 1'b0;
      bus_a.leer = 1'b0;
      bus_b.leer = 1'b0;
      test_reset();
      test_sequence();
      test_back_to_back();
      test_reset_abort();
      test_hold2();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
